// File: rtl/pc_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pc_stack_unit
//  Description : Program counter with increment, skip, jump, call/return
//                through a hardware return stack, and sticky overflow and
//                underflow reporting. Advances once per enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module pc_stack_unit #(
    parameter int PC_WIDTH     = 11,
    parameter int STACK_DEPTH  = 8,
    parameter int RESET_VECTOR = 0,
    parameter int WRAP_STACK   = 1
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 en,
    input  logic [2:0]                           op,
    input  logic [PC_WIDTH-1:0]                  target,
    input  logic                                 clr_flags,
    output logic [PC_WIDTH-1:0]                  counter,
    output logic [$clog2(STACK_DEPTH+1)-1:0]     depth,
    output logic                                 stack_full,
    output logic                                 stack_empty,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int SP_W    = $clog2(STACK_DEPTH);
    localparam int DEPTH_W = $clog2(STACK_DEPTH+1);

    localparam logic [2:0] c_op_inc    = 3'd0;
    localparam logic [2:0] c_op_skip   = 3'd1;
    localparam logic [2:0] c_op_goto   = 3'd2;
    localparam logic [2:0] c_op_call   = 3'd3;
    localparam logic [2:0] c_op_return = 3'd4;
    localparam logic [2:0] c_op_hold   = 3'd5;

    localparam logic [PC_WIDTH-1:0] c_reset_pc  = PC_WIDTH'(RESET_VECTOR);
    localparam logic [SP_W-1:0]     c_sp_last   = SP_W'(STACK_DEPTH - 1);
    localparam logic [DEPTH_W-1:0]  c_depth_max = DEPTH_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] counter_q,   counter_d;
    logic [SP_W-1:0]     sp_q,        sp_d;
    logic [DEPTH_W-1:0]  depth_q,     depth_d;
    logic                overflow_q,  overflow_d;
    logic                underflow_q, underflow_d;
    logic [PC_WIDTH-1:0] stk_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stk_d [STACK_DEPTH];

    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [PC_WIDTH-1:0] w_pc_skip;
    logic [SP_W-1:0]     w_sp_inc;
    logic [SP_W-1:0]     w_sp_dec;
    logic [PC_WIDTH-1:0] w_pop_data;
    logic                w_full;
    logic                w_empty;

    // Successor PCs and circular pointer neighbours (explicit wrap so
    // non-power-of-two depths still cycle through exactly STACK_DEPTH slots).
    always_comb begin
        w_pc_inc   = counter_q + PC_WIDTH'(1);
        w_pc_skip  = counter_q + PC_WIDTH'(2);
        w_sp_inc   = (sp_q == c_sp_last) ? '0 : sp_q + SP_W'(1);
        w_sp_dec   = (sp_q == '0) ? c_sp_last : sp_q - SP_W'(1);
        w_pop_data = stk_q[w_sp_dec];
        w_full     = (depth_q == c_depth_max);
        w_empty    = (depth_q == '0);
    end

    // Next-state decode: flag clear is applied first so a same-edge set wins.
    always_comb begin
        counter_d   = counter_q;
        sp_d        = sp_q;
        depth_d     = depth_q;
        stk_d       = stk_q;
        overflow_d  = overflow_q  & ~clr_flags;
        underflow_d = underflow_q & ~clr_flags;

        if (en) begin
            case (op)
                c_op_skip: counter_d = w_pc_skip;
                c_op_goto: counter_d = target;
                c_op_hold: counter_d = counter_q;
                c_op_call: begin
                    counter_d = target;
                    if (!w_full) begin
                        stk_d[sp_q] = w_pc_inc;
                        sp_d        = w_sp_inc;
                        depth_d     = depth_q + DEPTH_W'(1);
                    end else begin
                        overflow_d = 1'b1;
                        // Circular stack overwrites the oldest entry; the
                        // guarded stack drops the push but still jumps.
                        if (WRAP_STACK != 0) begin
                            stk_d[sp_q] = w_pc_inc;
                            sp_d        = w_sp_inc;
                        end
                    end
                end
                c_op_return: begin
                    if (!w_empty) begin
                        counter_d = w_pop_data;
                        sp_d      = w_sp_dec;
                        depth_d   = depth_q - DEPTH_W'(1);
                    end else begin
                        underflow_d = 1'b1;
                        // Circular stack returns the stale entry below sp;
                        // the guarded stack degrades to a plain increment.
                        if (WRAP_STACK != 0) begin
                            counter_d = w_pop_data;
                            sp_d      = w_sp_dec;
                        end else begin
                            counter_d = w_pc_inc;
                        end
                    end
                end
                default: counter_d = w_pc_inc;
            endcase
        end
    end

    // State registers; reset discards any operation on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter_q   <= c_reset_pc;
            sp_q        <= '0;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            counter_q   <= counter_d;
            sp_q        <= sp_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            stk_q       <= stk_d;
        end
    end

    // Outputs straight from registers; full/empty decode from depth only.
    always_comb begin
        counter     = counter_q;
        depth       = depth_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
        stack_full  = w_full;
        stack_empty = w_empty;
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_stack_unit
//  Description : Scoreboard bench for pc_stack_unit. One instance uses the
//                circular stack, a second the guarded stack. Stimulus pushes
//                hand-computed expectations; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_stack_unit;

    localparam int PCW = 11;
    localparam int SD  = 8;
    localparam int DW  = 4;

    localparam logic [2:0] INC = 3'd0, SKIP = 3'd1, GOTO = 3'd2,
                           CALL = 3'd3, RET = 3'd4, HOLD = 3'd5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // circular-stack instance (w) and guarded-stack instance (g)
    logic           reset_w = 1'b1, en_w = 1'b0, clr_w = 1'b0;
    logic [2:0]     op_w = 3'd0;
    logic [PCW-1:0] tgt_w = '0;
    logic [PCW-1:0] counter_w;
    logic [DW-1:0]  depth_w;
    logic           full_w, empty_w, ovf_w, unf_w;

    logic           reset_g = 1'b1, en_g = 1'b0, clr_g = 1'b0;
    logic [2:0]     op_g = 3'd0;
    logic [PCW-1:0] tgt_g = '0;
    logic [PCW-1:0] counter_g;
    logic [DW-1:0]  depth_g;
    logic           full_g, empty_g, ovf_g, unf_g;

    pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(SD), .RESET_VECTOR(0), .WRAP_STACK(1)) dut_w (
        .clk(clk), .reset(reset_w), .en(en_w), .op(op_w), .target(tgt_w),
        .clr_flags(clr_w), .counter(counter_w), .depth(depth_w),
        .stack_full(full_w), .stack_empty(empty_w),
        .overflow(ovf_w), .underflow(unf_w)
    );

    pc_stack_unit #(.PC_WIDTH(PCW), .STACK_DEPTH(SD), .RESET_VECTOR(0), .WRAP_STACK(0)) dut_g (
        .clk(clk), .reset(reset_g), .en(en_g), .op(op_g), .target(tgt_g),
        .clr_flags(clr_g), .counter(counter_g), .depth(depth_g),
        .stack_full(full_g), .stack_empty(empty_g),
        .overflow(ovf_g), .underflow(unf_g)
    );

    typedef struct packed {
        logic           sel;
        int             due;
        logic [PCW-1:0] pc;
        logic [DW-1:0]  dep;
        logic           ovf;
        logic           unf;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    cyc     = 0;
    int    n_cmp   = 0;
    int    n_bad   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each expectation becomes due one edge after it was issued.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t  e;
            string nm;
            logic [PCW-1:0] a_pc;
            logic [DW-1:0]  a_dep;
            logic a_ovf, a_unf, a_full, a_empty, e_full, e_empty;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (e.sel) begin
                a_pc = counter_g; a_dep = depth_g; a_ovf = ovf_g; a_unf = unf_g;
                a_full = full_g; a_empty = empty_g;
            end else begin
                a_pc = counter_w; a_dep = depth_w; a_ovf = ovf_w; a_unf = unf_w;
                a_full = full_w; a_empty = empty_w;
            end
            e_full  = (e.dep == DW'(SD));
            e_empty = (e.dep == '0);
            n_cmp++;
            if (a_pc !== e.pc || a_dep !== e.dep || a_ovf !== e.ovf ||
                a_unf !== e.unf || a_full !== e_full || a_empty !== e_empty) begin
                n_bad++;
                $display("FAIL %s: got pc=%0d depth=%0d ovf=%b unf=%b full=%b empty=%b, expected pc=%0d depth=%0d ovf=%b unf=%b full=%b empty=%b",
                         nm, a_pc, a_dep, a_ovf, a_unf, a_full, a_empty,
                         e.pc, e.dep, e.ovf, e.unf, e_full, e_empty);
            end
        end
    end

    // Drive one cycle on the selected instance and queue its expected state.
    task automatic step(input bit sel, input logic [2:0] o, input int t,
                        input bit e, input bit c, input bit r,
                        input int ep, input int ed, input bit eo, input bit eu,
                        input string nm);
        exp_t x;
        @(negedge clk);
        reset_w = 1'b0; en_w = 1'b0; clr_w = 1'b0; op_w = INC; tgt_w = '0;
        reset_g = 1'b0; en_g = 1'b0; clr_g = 1'b0; op_g = INC; tgt_g = '0;
        if (sel) begin
            reset_g = r; en_g = e; clr_g = c; op_g = o; tgt_g = PCW'(t);
        end else begin
            reset_w = r; en_w = e; clr_w = c; op_w = o; tgt_w = PCW'(t);
        end
        x.sel = sel; x.due = cyc + 1; x.pc = PCW'(ep); x.dep = DW'(ed);
        x.ovf = eo; x.unf = eu;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        // ---------------- circular instance ----------------
        step(0, INC, 0, 1, 0, 1, 0, 0, 0, 0, "w_reset");
        for (int i = 1; i <= 5; i++) step(0, INC, 0, 1, 0, 0, i, 0, 0, 0, "w_inc");
        step(0, GOTO, 2047, 1, 0, 0, 2047, 0, 0, 0, "w_goto_top");
        step(0, INC,  0,    1, 0, 0, 0,    0, 0, 0, "w_inc_wrap");
        step(0, GOTO, 2047, 1, 0, 0, 2047, 0, 0, 0, "w_goto_top2");
        step(0, SKIP, 0,    1, 0, 0, 1,    0, 0, 0, "w_skip_wrap");
        step(0, GOTO, 10,   1, 0, 0, 10,   0, 0, 0, "w_goto10");
        step(0, SKIP, 0,    1, 0, 0, 12,   0, 0, 0, "w_skip");
        step(0, GOTO, 'h155,1, 0, 0, 'h155,0, 0, 0, "w_goto155");
        step(0, INC,  0,    0, 0, 0, 'h155,0, 0, 0, "w_en0");
        step(0, HOLD, 0,    1, 0, 0, 'h155,0, 0, 0, "w_hold");
        step(0, GOTO, 4,    1, 0, 0, 4,    0, 0, 0, "w_goto4");
        step(0, CALL, 100,  1, 0, 0, 100,  1, 0, 0, "w_call100");
        step(0, CALL, 200,  1, 0, 0, 200,  2, 0, 0, "w_call200");
        step(0, RET,  0,    1, 0, 0, 101,  1, 0, 0, "w_ret1");
        step(0, RET,  0,    1, 0, 0, 5,    0, 0, 0, "w_ret2");
        // nine calls: pushes 6,17,33,...,129; the 9th overwrites the oldest
        for (int k = 0; k < 9; k++)
            step(0, CALL, 16*(k+1), 1, 0, 0, 16*(k+1), (k < 8) ? k+1 : 8, k == 8, 0, "w_ovf_call");
        step(0, RET, 0, 1, 0, 0, 129, 7, 1, 0, "w_ovf_ret_newest");
        for (int k = 6; k >= 0; k--)
            step(0, RET, 0, 1, 0, 0, 16*(k+1)+1, k, 1, 0, "w_ovf_ret");
        // empty pop returns the stale slot below sp (slot 0 holds 129)
        step(0, RET,  0, 1, 0, 0, 129, 0, 1, 1, "w_unf_stale");
        step(0, INC,  0, 0, 1, 0, 129, 0, 0, 0, "w_clr_en0");
        step(0, CALL, 300, 1, 0, 0, 300, 1, 0, 0, "w_pre_c1");
        step(0, CALL, 400, 1, 0, 0, 400, 2, 0, 0, "w_pre_c2");
        step(0, CALL, 500, 1, 0, 0, 500, 3, 0, 0, "w_pre_c3");
        step(0, CALL, 600, 1, 0, 1, 0,   0, 0, 0, "w_reset_mid_call");
        step(0, GOTO, 700, 1, 0, 1, 0,   0, 0, 0, "w_reset_held");
        // stack contents were cleared, so the stale empty pop yields 0
        step(0, RET,  0,   1, 0, 0, 0,   0, 0, 1, "w_unf_after_reset");

        // ---------------- guarded instance ----------------
        step(1, INC, 0, 1, 0, 1, 0, 0, 0, 0, "g_reset");
        step(1, RET, 0, 1, 0, 0, 1, 0, 0, 1, "g_unf_inc");
        step(1, INC, 0, 0, 1, 0, 1, 0, 0, 0, "g_clr");
        step(1, RET, 0, 1, 1, 0, 2, 0, 0, 1, "g_clr_vs_set");
        step(1, INC, 0, 0, 1, 0, 2, 0, 0, 0, "g_clr2");
        // pushes 3,17,...,113; the 9th (129) is dropped but the jump is taken
        for (int k = 0; k < 9; k++)
            step(1, CALL, 16*(k+1), 1, 0, 0, 16*(k+1), (k < 8) ? k+1 : 8, k == 8, 0, "g_ovf_call");
        for (int k = 7; k >= 1; k--)
            step(1, RET, 0, 1, 0, 0, 16*k+1, k, 1, 0, "g_ovf_ret");
        step(1, RET, 0, 1, 0, 0, 3, 0, 1, 0, "g_ret_oldest");
        step(1, RET, 0, 1, 0, 0, 4, 0, 1, 1, "g_unf_after");

        @(negedge clk);
        reset_w = 1'b0; en_w = 1'b0; clr_w = 1'b0;
        reset_g = 1'b0; en_g = 1'b0; clr_g = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit with an integrated hardware return stack; successor to `pcounter`. It supplies the ROM fetch address (`counter`) and adds the following to the existing sequential increment:
- skip (PC+2) for bit-test/decrement-skip instructions
- absolute jump for GOTO
- CALL/RETURN through a configurable-depth stack
- sticky overflow/underflow reporting

The unit advances once per instruction cycle, gated by `en`, which the decoder drives from the `clk1` phase.

## Interface
Parameters:
- `PC_WIDTH`, default 11: width of `counter` and `target`; the PC wraps modulo 2^PC_WIDTH.
- `STACK_DEPTH`, default 8: number of return-address entries, must be ≥ 2.
- `RESET_VECTOR`, default 0: PC value after reset.
- `WRAP_STACK`, default 1: 1 selects a circular stack (PIC-style); 0 selects a guarded stack.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-high; dominates every other input.
- `en` input 1: instruction-advance strobe; while 0, all state holds.
- `op` input 3: 0 INC, 1 SKIP, 2 GOTO, 3 CALL, 4 RETURN, 5 HOLD; 6 and 7 behave as INC.
- `target` input PC_WIDTH: jump address for GOTO and CALL.
- `clr_flags` input 1: clears the sticky `overflow` and `underflow` flags.
- `counter` output PC_WIDTH: current PC, registered.
- `depth` output $clog2(STACK_DEPTH+1): number of valid stack entries.
- `stack_full` output 1: high when depth == STACK_DEPTH (combinational from `depth`).
- `stack_empty` output 1: high when depth == 0 (combinational from `depth`).
- `overflow` output 1: sticky; set by a CALL issued while the stack is full.
- `underflow` output 1: sticky; set by a RETURN issued while the stack is empty.

## Operation
- Internal state:
  - stack array `stk[STACK_DEPTH]`
  - write pointer `sp`, range 0..STACK_DEPTH-1, wraps modulo STACK_DEPTH
  - `depth` counter
- Reset (rising edge with `reset`=1):
  - `counter`=RESET_VECTOR, `sp`=0, `depth`=0, `overflow`=0, `underflow`=0, all `stk` entries = 0.
  - Outputs after reset: `stack_empty`=1, `stack_full`=0.
- When `en`=1, the next PC is:
  - INC: `counter`+1, mod 2^PC_WIDTH.
  - SKIP: `counter`+2, mod 2^PC_WIDTH.
  - GOTO: `target`.
  - CALL: `target`; also pushes `counter`+1 (mod 2^PC_WIDTH).
  - RETURN: the popped entry `stk[sp-1]` (index mod STACK_DEPTH).
  - HOLD: `counter` unchanged.
- Push (CALL):
  - Not full: `stk[sp]` ← `counter`+1, `sp`+1, `depth`+1.
  - Full with WRAP_STACK=1: overwrite `stk[sp]`, `sp`+1, `depth` stays at STACK_DEPTH, `overflow` ← 1.
  - Full with WRAP_STACK=0: push dropped, `sp` and `depth` unchanged, jump still taken, `overflow` ← 1.
- Pop (RETURN):
  - Not empty: `counter` ← `stk[sp-1]`, `sp`−1, `depth`−1.
  - Empty with WRAP_STACK=1: `counter` ← `stk[sp-1]` (stale circular entry), `sp`−1, `depth` stays 0, `underflow` ← 1.
  - Empty with WRAP_STACK=0: `counter` ← `counter`+1 (treated as INC), `sp` unchanged, `underflow` ← 1.
- `clr_flags`:
  - Acts independently of `en`.
  - If `clr_flags` and a flag-setting event occur on the same edge, the set wins.
- `en`=0: `counter`, `sp`, `depth` and `stk` hold. Only `clr_flags` and `reset` take effect.
- Width rule: all PC arithmetic is truncated to PC_WIDTH bits; no carry is exported.

## Timing
- Single-cycle latency: inputs sampled on edge N appear on `counter` and `depth` after edge N; no combinational path from `op` or `target` to `counter`.
- The stack array is read using the registered `sp`, so the RETURN target is available without a bypass. A CALL followed by a RETURN on consecutive enabled edges returns `counter`+1 as captured at the CALL.
- Reset mid-operation: an in-flight CALL/RETURN on the reset edge is discarded, and all state returns to reset values that same edge.
- `reset` held high keeps `counter`=RESET_VECTOR regardless of `en` and `op`.

## Test plan
- Reset and increment:
  - Stimulus: reset pulse, then 5 enabled INC cycles.
  - Required: `counter` 0→5, `stack_empty`=1, all flags 0.
  - Wrap: with PC_WIDTH=11 and PC=2047, INC gives 0 and SKIP gives 1.
- SKIP, GOTO and HOLD:
  - From PC=10: SKIP gives 12; GOTO with `target`=0x155 gives 0x155.
  - With `en`=0, or with HOLD, PC stays 0x155.
- Nested CALL/RETURN:
  - From PC=4: CALL 100, then CALL 200 at PC=100, then RETURN, RETURN.
  - Required: PC sequence 100, 200, 101, 5; `depth` 1, 2, 1, 0.
- Overflow:
  - Stimulus: STACK_DEPTH=8, WRAP_STACK=1, 9 consecutive CALLs.
  - Required: `overflow`=1 and `depth`=8 after the 9th CALL; the 8 RETURNs then yield the last 8 return addresses, with the oldest lost.
  - Repeat with WRAP_STACK=0: the 9th return address is dropped, the jump is still taken, and `overflow`=1.
- Underflow:
  - RETURN on an empty stack with WRAP_STACK=0: PC+1, `underflow`=1.
  - `clr_flags` then clears it; `clr_flags` coincident with a new underflow leaves it set.
- Reset mid-CALL:
  - Assert `reset` on the same edge as a CALL with `depth`=3.
  - Required: `counter`=RESET_VECTOR, `depth`=0, flags 0.
